// File: rtl/rv6_biu_pkg.sv
// Shared types and helpers for the rv6 bus interface unit.
// Size codes are log2 of the access width in bytes.
package rv6_biu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUS  = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [1:0] SZ_B = 2'd0;
    localparam logic [1:0] SZ_H = 2'd1;
    localparam logic [1:0] SZ_W = 2'd2;
    localparam logic [1:0] SZ_D = 2'd3;

    // Number of external beats needed for one access; never less than one.
    function automatic int beats(input logic [1:0] size, input int xbus_w, input int word_w);
        int bits;
        int n;
        bits = 32'sd8 << size;
        bits = (bits > word_w) ? word_w : bits;
        n    = bits / xbus_w;
        return (n < 32'sd1) ? 32'sd1 : n;
    endfunction

    // Byte-lane mask for an access at lane offset addr_lo; callers keep the
    // low XBUS_W/8 bits, which come out all-ones for full-width beats.
    function automatic logic [15:0] lane_be(input logic [2:0] addr_lo, input logic [1:0] size);
        logic [15:0] m;
        m = (16'd1 << (5'd1 << size)) - 16'd1;
        return m << addr_lo;
    endfunction

endpackage

// File: rtl/rv6_biu_if.sv
// Internal request/response port plus external physical bus of the rv6 BIU.
interface rv6_biu_if #(
    parameter int PHY_ADDR = 48,
    parameter int XBUS_W   = 16,
    parameter int WORD_W   = 64
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [PHY_ADDR-1:0]   req_addr;
    logic [1:0]            req_size;
    logic [WORD_W-1:0]     req_wdata;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [WORD_W-1:0]     rsp_rdata;
    logic                  rsp_err;
    logic [PHY_ADDR-1:0]   addr;
    logic [XBUS_W-1:0]     data_in;
    logic [XBUS_W-1:0]     data_out;
    logic [XBUS_W/8-1:0]   be;
    logic                  rd;
    logic                  wr;
    logic                  dbv;

    modport slave (
        input  req_valid, req_we, req_addr, req_size, req_wdata, rsp_ready, data_in, dbv,
        output req_ready, rsp_valid, rsp_rdata, rsp_err, addr, data_out, be, rd, wr
    );

    modport master (
        output req_valid, req_we, req_addr, req_size, req_wdata, rsp_ready, data_in, dbv,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err, addr, data_out, be, rd, wr
    );
endinterface

// File: rtl/rv6_bus_timer.sv
// Per-beat dbv watchdog: loaded with TIMEOUT, counts down on idle bus cycles.
// o_expire flags that the next idle cycle is the last one allowed.
module rv6_bus_timer #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_load,
    input  logic i_clear,
    input  logic i_tick,
    output logic o_expire
);
    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] r_count;

    // Down-counter with load priority over clear and tick.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= CW'(TIMEOUT);
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_tick && (r_count != '0)) begin
            r_count <= r_count - CW'(1);
        end else begin
            r_count <= r_count;
        end
    end

    assign o_expire = (r_count == CW'(1));
endmodule

// File: rtl/rv6_biu.sv
// rv6 bus interface unit: splits one internal access into little-endian
// external beats, drives byte enables and aborts on misalignment or dbv timeout.
module rv6_biu
    import rv6_biu_pkg::*;
#(
    parameter int PHY_ADDR = 48,
    parameter int XBUS_W   = 16,
    parameter int WORD_W   = 64,
    parameter int TIMEOUT  = 255
) (
    input logic      clk,
    input logic      rst_n,
    rv6_biu_if.slave io_bus
);
    localparam int XB    = XBUS_W / 8;
    localparam int OFFW  = (XB > 1) ? $clog2(XB) : 1;
    localparam int NBMAX = WORD_W / XBUS_W;
    localparam int BW    = (NBMAX > 1) ? $clog2(NBMAX) : 1;

    state_t              r_state, w_state;
    logic                r_we, w_we;
    logic [1:0]          r_size, w_size;
    logic [WORD_W-1:0]   r_wdata, w_wdata;
    logic [OFFW-1:0]     r_off, w_off;
    logic [BW-1:0]       r_beat, w_beat, r_last, w_last;
    logic [PHY_ADDR-1:0] r_addr, w_addr;
    logic [XBUS_W-1:0]   r_dout, w_dout;
    logic [XB-1:0]       r_be, w_be;
    logic                r_rd, w_rd, r_wr, w_wr;
    logic                r_rsp_valid, w_rsp_valid, r_err, w_err;
    logic [WORD_W-1:0]   r_rdata, w_rdata;
    logic                w_tmr_load, w_tmr_clear, w_tmr_tick, w_tmr_expire;
    logic [OFFW-1:0]     w_req_off;
    logic [15:0]         w_lane;
    logic                w_misalign, w_oversize;
    logic [3:0]          w_nbytes;
    logic [XBUS_W-1:0]   w_shift;

    // Write data for beat k; narrow writes are replicated across every lane.
    function automatic logic [XBUS_W-1:0] beat_data(input logic [WORD_W-1:0] wd,
                                                    input logic [1:0] size,
                                                    input logic [BW-1:0] k);
        logic [XBUS_W-1:0] d;
        int nb;
        nb = 32'sd1 << size;
        for (int j = 0; j < XB; j++) begin
            d[j*8 +: 8] = (nb >= XB) ? wd[(int'(k) * XB + j) * 8 +: 8] : wd[(j % nb) * 8 +: 8];
        end
        return d;
    endfunction

    assign w_req_off  = OFFW'(io_bus.req_addr) & OFFW'(XB - 1);
    assign w_lane     = lane_be(3'(w_req_off), io_bus.req_size);
    assign w_misalign = (io_bus.req_addr[2:0] & ((3'd1 << io_bus.req_size) - 3'd1)) != 3'd0;
    assign w_oversize = (32'sd8 << io_bus.req_size) > WORD_W;
    assign w_nbytes   = 4'd1 << r_size;
    assign w_shift    = io_bus.data_in >> {r_off, 3'b000};

    rv6_bus_timer #(.TIMEOUT(TIMEOUT)) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .i_load   (w_tmr_load),
        .i_clear  (w_tmr_clear),
        .i_tick   (w_tmr_tick),
        .o_expire (w_tmr_expire)
    );

    // Next-state and next-output logic for the IDLE/BUS/RESP sequencer.
    always_comb begin
        w_state     = r_state;
        w_we        = r_we;
        w_size      = r_size;
        w_wdata     = r_wdata;
        w_off       = r_off;
        w_beat      = r_beat;
        w_last      = r_last;
        w_addr      = r_addr;
        w_dout      = r_dout;
        w_be        = r_be;
        w_rd        = r_rd;
        w_wr        = r_wr;
        w_rsp_valid = r_rsp_valid;
        w_err       = r_err;
        w_rdata     = r_rdata;
        w_tmr_load  = 1'b0;
        w_tmr_clear = 1'b0;
        w_tmr_tick  = 1'b0;
        case (r_state)
            IDLE: begin
                if (io_bus.req_valid) begin
                    w_we    = io_bus.req_we;
                    w_size  = io_bus.req_size;
                    w_wdata = io_bus.req_wdata;
                    w_off   = w_req_off;
                    w_beat  = '0;
                    w_last  = BW'(beats(io_bus.req_size, XBUS_W, WORD_W) - 1);
                    w_rdata = '0;
                    if (w_misalign || w_oversize) begin
                        w_state     = RESP;
                        w_rsp_valid = 1'b1;
                        w_err       = 1'b1;
                    end else begin
                        w_state    = BUS;
                        w_err      = 1'b0;
                        w_addr     = io_bus.req_addr & ~PHY_ADDR'(XB - 1);
                        w_rd       = ~io_bus.req_we;
                        w_wr       = io_bus.req_we;
                        w_be       = w_lane[XB-1:0];
                        w_dout     = io_bus.req_we ? beat_data(io_bus.req_wdata, io_bus.req_size, '0)
                                                   : '0;
                        w_tmr_load = 1'b1;
                    end
                end else begin
                    w_state = IDLE;
                end
            end
            BUS: begin
                if (io_bus.dbv && (r_rd || r_wr)) begin
                    if (r_we) begin
                        w_rdata = r_rdata;
                    end else if (int'(w_nbytes) < XB) begin
                        for (int j = 0; j < XB; j++) begin
                            w_rdata[j*8 +: 8] = (j < int'(w_nbytes)) ? w_shift[j*8 +: 8] : 8'h00;
                        end
                    end else begin
                        w_rdata[int'(r_beat) * XBUS_W +: XBUS_W] = io_bus.data_in;
                    end
                    if (r_beat == r_last) begin
                        w_rd        = 1'b0;
                        w_wr        = 1'b0;
                        w_be        = '0;
                        w_state     = RESP;
                        w_rsp_valid = 1'b1;
                        w_err       = 1'b0;
                        w_tmr_clear = 1'b1;
                    end else begin
                        w_beat     = r_beat + BW'(1);
                        w_addr     = r_addr + PHY_ADDR'(XB);
                        w_dout     = r_we ? beat_data(r_wdata, r_size, r_beat + BW'(1)) : '0;
                        w_tmr_load = 1'b1;
                    end
                end else begin
                    w_tmr_tick = 1'b1;
                    if (w_tmr_expire) begin
                        w_rd        = 1'b0;
                        w_wr        = 1'b0;
                        w_be        = '0;
                        w_state     = RESP;
                        w_rsp_valid = 1'b1;
                        w_err       = 1'b1;
                        w_tmr_clear = 1'b1;
                    end else begin
                        w_state = BUS;
                    end
                end
            end
            RESP: begin
                if (io_bus.rsp_ready) begin
                    w_rsp_valid = 1'b0;
                    w_state     = IDLE;
                end else begin
                    w_state = RESP;
                end
            end
            default: begin
                w_state = IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_we        <= 1'b0;
            r_size      <= 2'd0;
            r_wdata     <= '0;
            r_off       <= '0;
            r_beat      <= '0;
            r_last      <= '0;
            r_addr      <= '0;
            r_dout      <= '0;
            r_be        <= '0;
            r_rd        <= 1'b0;
            r_wr        <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_err       <= 1'b0;
            r_rdata     <= '0;
        end else begin
            r_state     <= w_state;
            r_we        <= w_we;
            r_size      <= w_size;
            r_wdata     <= w_wdata;
            r_off       <= w_off;
            r_beat      <= w_beat;
            r_last      <= w_last;
            r_addr      <= w_addr;
            r_dout      <= w_dout;
            r_be        <= w_be;
            r_rd        <= w_rd;
            r_wr        <= w_wr;
            r_rsp_valid <= w_rsp_valid;
            r_err       <= w_err;
            r_rdata     <= w_rdata;
        end
    end

    assign io_bus.req_ready = (r_state == IDLE);
    assign io_bus.rsp_valid = r_rsp_valid;
    assign io_bus.rsp_rdata = r_rdata;
    assign io_bus.rsp_err   = r_err;
    assign io_bus.addr      = r_addr;
    assign io_bus.data_out  = r_dout;
    assign io_bus.be        = r_be;
    assign io_bus.rd        = r_rd;
    assign io_bus.wr        = r_wr;
endmodule

// File: tb/tb_rv6_biu.sv
// Directed bench for rv6_biu: vector table of single accesses plus
// timeout, backpressure and mid-beat reset sequences.
module tb_rv6_biu;
    localparam int PA = 48;
    localparam int XW = 16;
    localparam int WW = 64;
    localparam int TO = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    rv6_biu_if #(.PHY_ADDR(PA), .XBUS_W(XW), .WORD_W(WW)) bus_if ();

    rv6_biu #(.PHY_ADDR(PA), .XBUS_W(XW), .WORD_W(WW), .TIMEOUT(TO)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .io_bus (bus_if)
    );

    typedef struct {
        logic             we;
        logic [47:0]      addr;
        logic [1:0]       size;
        logic [63:0]      wdata;
        int               nb;
        logic [47:0]      baddr;
        logic [1:0]       be;
        logic [3:0][15:0] dout;
        logic [3:0][15:0] din;
        logic [63:0]      rdata;
        logic             err;
    } vec_t;

    vec_t vt[12];
    int n_pass = 0;
    int n_tot  = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_tot++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic we, input logic [47:0] a, input logic [1:0] sz,
                                input logic [63:0] wd, input int nb, input logic [47:0] ba,
                                input logic [1:0] be, input logic [63:0] dout,
                                input logic [63:0] din, input logic [63:0] rdata, input logic err);
        vec_t v;
        v.we = we; v.addr = a; v.size = sz; v.wdata = wd; v.nb = nb; v.baddr = ba;
        v.be = be; v.dout = dout; v.din = din; v.rdata = rdata; v.err = err;
        return v;
    endfunction

    task automatic issue(input logic we, input logic [47:0] a, input logic [1:0] sz, input logic [63:0] wd);
        bus_if.req_we    = we;
        bus_if.req_addr  = a;
        bus_if.req_size  = sz;
        bus_if.req_wdata = wd;
        bus_if.req_valid = 1'b1;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int cyc;
        int k;
        chk($sformatf("v%0d_req_ready", idx), bus_if.req_ready, 1'b1);
        bus_if.dbv = 1'b1;
        bus_if.rsp_ready = 1'b1;
        issue(v.we, v.addr, v.size, v.wdata);
        @(negedge clk);
        bus_if.req_valid = 1'b0;
        cyc = 1;
        k = 0;
        while (!bus_if.rsp_valid && cyc < 20) begin
            if (k < v.nb) begin
                chk($sformatf("v%0d_beat%0d", idx, k),
                    {bus_if.rd, bus_if.wr, bus_if.addr, bus_if.be, bus_if.data_out},
                    {~v.we, v.we, v.baddr + 48'(2 * k), v.be, v.dout[k]});
                bus_if.data_in = v.din[k];
            end else begin
                chk($sformatf("v%0d_extra_beat", idx), {bus_if.rd, bus_if.wr}, 2'b00);
            end
            k++;
            @(negedge clk);
            cyc++;
        end
        chk($sformatf("v%0d_latency", idx), cyc, v.nb + 1);
        chk($sformatf("v%0d_err", idx), bus_if.rsp_err, v.err);
        chk($sformatf("v%0d_strobes_off", idx), {bus_if.rd, bus_if.wr, bus_if.be}, 4'b0000);
        if (!v.we) begin
            chk($sformatf("v%0d_rdata", idx), bus_if.rsp_rdata, v.rdata);
        end
        @(negedge clk);
        chk($sformatf("v%0d_rsp_drop", idx), {bus_if.rsp_valid, bus_if.req_ready}, 2'b01);
    endtask

    // dbv withheld after an optional first beat; expects TO cycles of rd then an error.
    task automatic tmo(input logic [1:0] sz, input logic [47:0] a, input bit one_beat,
                       input logic [63:0] exp_rdata);
        int cnt;
        bus_if.rsp_ready = 1'b1;
        bus_if.dbv = one_beat;
        issue(1'b0, a, sz, 64'h0);
        @(negedge clk);
        bus_if.req_valid = 1'b0;
        if (one_beat) begin
            chk("tmo_first_beat_rd", bus_if.rd, 1'b1);
            bus_if.data_in = 16'h5555;
            @(negedge clk);
            bus_if.dbv = 1'b0;
        end
        cnt = 0;
        while (bus_if.rd && cnt < 40) begin
            cnt++;
            @(negedge clk);
        end
        chk("tmo_rd_cycles", cnt, TO);
        chk("tmo_rsp", {bus_if.rsp_valid, bus_if.rsp_err, bus_if.rd, bus_if.wr}, 4'b1100);
        chk("tmo_rdata", bus_if.rsp_rdata, exp_rdata);
        bus_if.dbv = 1'b1;
        @(negedge clk);
        chk("tmo_idle", {bus_if.rsp_valid, bus_if.req_ready}, 2'b01);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        bus_if.req_valid = 1'b0;
        bus_if.req_we    = 1'b0;
        bus_if.req_addr  = 48'h0;
        bus_if.req_size  = 2'd0;
        bus_if.req_wdata = 64'h0;
        bus_if.rsp_ready = 1'b1;
        bus_if.data_in   = 16'h0;
        bus_if.dbv       = 1'b1;

        vt[0]  = mk(1'b0, 48'h1000, 2'd3, 64'h0, 4, 48'h1000, 2'b11, 64'h0,
                    64'h4444_3333_2222_1111, 64'h4444_3333_2222_1111, 1'b0);
        vt[1]  = mk(1'b1, 48'h2003, 2'd0, 64'hA5, 1, 48'h2002, 2'b10, 64'hA5A5, 64'h0, 64'h0, 1'b0);
        vt[2]  = mk(1'b0, 48'h3002, 2'd2, 64'h0, 0, 48'h0, 2'b00, 64'h0, 64'h0, 64'h0, 1'b1);
        vt[3]  = mk(1'b0, 48'h4001, 2'd0, 64'h0, 1, 48'h4000, 2'b10, 64'h0, 64'hBE00, 64'hBE, 1'b0);
        vt[4]  = mk(1'b0, 48'h5006, 2'd1, 64'h0, 1, 48'h5006, 2'b11, 64'h0, 64'h1234, 64'h1234, 1'b0);
        vt[5]  = mk(1'b1, 48'h6004, 2'd2, 64'hDEAD_BEEF, 2, 48'h6004, 2'b11, 64'hDEAD_BEEF,
                    64'h0, 64'h0, 1'b0);
        vt[6]  = mk(1'b0, 48'h7001, 2'd1, 64'h0, 0, 48'h0, 2'b00, 64'h0, 64'h0, 64'h0, 1'b1);
        vt[7]  = mk(1'b0, 48'h8000, 2'd0, 64'h0, 1, 48'h8000, 2'b01, 64'h0, 64'h77CD, 64'hCD, 1'b0);
        vt[8]  = mk(1'b1, 48'h9008, 2'd3, 64'h0123_4567_89AB_CDEF, 4, 48'h9008, 2'b11,
                    64'h0123_4567_89AB_CDEF, 64'h0, 64'h0, 1'b0);
        vt[9]  = mk(1'b1, 48'h9A02, 2'd1, 64'hFFFF_FFFF_FFFF_BEEF, 1, 48'h9A02, 2'b11, 64'hBEEF,
                    64'h0, 64'h0, 1'b0);
        vt[10] = mk(1'b0, 48'h9B04, 2'd3, 64'h0, 0, 48'h0, 2'b00, 64'h0, 64'h0, 64'h0, 1'b1);
        vt[11] = mk(1'b1, 48'h9C00, 2'd0, 64'h3C, 1, 48'h9C00, 2'b01, 64'h3C3C, 64'h0, 64'h0, 1'b0);

        repeat (2) @(negedge clk);
        chk("rst_bus", {bus_if.rd, bus_if.wr, bus_if.addr, bus_if.be, bus_if.data_out}, 68'h0);
        chk("rst_rsp", {bus_if.rsp_valid, bus_if.rsp_err, bus_if.rsp_rdata}, 66'h0);
        chk("rst_ready", bus_if.req_ready, 1'b1);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_dbv_ignored", {bus_if.rd, bus_if.wr, bus_if.rsp_valid, bus_if.req_ready}, 4'b0001);

        for (int i = 0; i < 12; i++) begin
            run_vec(vt[i], i);
        end

        tmo(2'd1, 48'hA000, 1'b0, 64'h0);
        tmo(2'd3, 48'hA100, 1'b1, 64'h5555);

        // Response backpressure with a request already waiting.
        bus_if.rsp_ready = 1'b0;
        bus_if.dbv = 1'b1;
        issue(1'b0, 48'hB000, 2'd1, 64'h0);
        @(negedge clk);
        bus_if.req_valid = 1'b0;
        bus_if.data_in = 16'h7777;
        @(negedge clk);
        issue(1'b0, 48'hB100, 2'd1, 64'h0);
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("bp_hold%0d", i), {bus_if.rsp_valid, bus_if.req_ready, bus_if.rd, bus_if.rsp_rdata},
                {3'b100, 64'h7777});
            @(negedge clk);
        end
        bus_if.rsp_ready = 1'b1;
        chk("bp_release_valid", {bus_if.rsp_valid, bus_if.req_ready}, 2'b10);
        @(negedge clk);
        chk("bp_idle", {bus_if.rsp_valid, bus_if.req_ready}, 2'b01);
        @(negedge clk);
        bus_if.req_valid = 1'b0;
        chk("bp_b2b_beat", {bus_if.rd, bus_if.addr}, {1'b1, 48'hB100});
        bus_if.data_in = 16'h8888;
        @(negedge clk);
        chk("bp_b2b_rsp", {bus_if.rsp_valid, bus_if.rsp_err, bus_if.rsp_rdata}, {2'b10, 64'h8888});
        @(negedge clk);

        // Asynchronous reset while beat 2 of 4 is on the bus.
        bus_if.dbv = 1'b1;
        issue(1'b0, 48'hC000, 2'd3, 64'h0);
        @(negedge clk);
        bus_if.req_valid = 1'b0;
        bus_if.data_in = 16'h0101;
        @(negedge clk);
        bus_if.dbv = 1'b0;
        chk("mid_beat_state", {bus_if.rd, bus_if.addr}, {1'b1, 48'hC002});
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst", {bus_if.rd, bus_if.wr, bus_if.addr, bus_if.rsp_valid}, 51'h0);
        @(negedge clk);
        rst_n = 1'b1;
        bus_if.dbv = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("post_rst%0d", i), {bus_if.req_ready, bus_if.rsp_valid, bus_if.rd}, 3'b100);
        end

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
